// File: rtl/lag_measure_ctrl_pkg.sv
// Shared definitions for the input-lag measurement controller.
// Holds the sequencer state encoding, the default lag width and the
// flash-frame constants that videogen uses to schedule test flashes.
package lag_measure_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARM     = 3'd1,
    ST_MEASURE = 3'd2,
    ST_HOLD    = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  // Width of lag values in microseconds; must be able to hold the timeout.
  localparam int LAG_LAT_W = 20;

  // Flash schedule used by videogen: one lit test field every N frames.
  localparam int FLASH_PERIOD_FRAMES = 30;
  localparam int FLASH_ON_FRAMES     = 1;

endpackage

// File: rtl/lag_sync_edge.sv
// Photodiode synchroniser and rising-edge detector.
// Ports:
//   clock  - pixel clock
//   reset  - synchronous, active-high reset
//   sensor - asynchronous comparator output, high means light
//   level  - synchronised sensor level (second flop)
//   rise   - one-cycle pulse on a synchronised rising edge
module lag_sync_edge (
  input  logic clock,
  input  logic reset,
  input  logic sensor,
  output logic level,
  output logic rise
);

  logic s1;
  logic s2;
  logic sd;

  always_ff @(posedge clock) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      sd <= 1'b0;
    end else begin
      s1 <= sensor;
      s2 <= s1;
      sd <= s2;
    end
  end

  assign level = s2;
  assign rise  = s2 & ~sd;

endmodule

// File: rtl/lag_measure_ctrl.sv
// Input-lag measurement sequencer.
// Arms on a button press, times each flash from the frame-start pulse to
// the photodiode rising edge in microsecond ticks, and accumulates
// last/min/max/average over SAMPLES measurements before triggering the
// text report.
//
// state   | meaning
// --------+---------------------------------------------------------
// IDLE    | no run in progress, statistics held
// ARM     | waiting for the next flash frame start
// MEASURE | counting ticks until photodiode edge or timeout
// HOLD    | waiting for the flash to go dark before re-arming
// DONE    | one cycle: pulse textgen_trigger, latch average
//
// Ports:
//   clock, reset      - pixel clock, synchronous active-high reset
//   starttrigger      - one-cycle pulse when a flash frame begins
//   sensor            - asynchronous photodiode comparator
//   button            - one-cycle request to (re)start a run
//   busy              - high in ARM, MEASURE and HOLD
//   textgen_trigger   - one-cycle pulse when a run completes
//   timeout           - sticky, a sample in this run timed out
//   sample_count      - valid samples taken in this run
//   lag_last/min/max  - sample statistics in us
//   lag_avg           - mean of the samples, updated when a run completes
module lag_measure_ctrl
  import lag_measure_ctrl_pkg::*;
#(
  parameter int US_DIV     = 74,
  parameter int SAMPLES    = 16,
  parameter int TIMEOUT_US = 500000,
  parameter int LAT_W      = LAG_LAT_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             starttrigger,
  input  logic             sensor,
  input  logic             button,
  output logic             busy,
  output logic             textgen_trigger,
  output logic             timeout,
  output logic [7:0]       sample_count,
  output logic [LAT_W-1:0] lag_last,
  output logic [LAT_W-1:0] lag_min,
  output logic [LAT_W-1:0] lag_max,
  output logic [LAT_W-1:0] lag_avg
);

  localparam int PW    = $clog2(US_DIV);
  localparam int SW    = $clog2(SAMPLES);
  localparam int SUM_W = LAT_W + SW;

  state_t             state;
  state_t             next_state;
  logic [PW-1:0]      presc;
  logic [LAT_W-1:0]   tick;
  logic [SUM_W-1:0]   sum;
  logic               level;
  logic               rise;
  logic               clear_run;
  logic               start_meas;
  logic               capture;
  logic               timed_out;
  logic               tick_at_limit;

  lag_sync_edge u_sync (
    .clock  (clock),
    .reset  (reset),
    .sensor (sensor),
    .level  (level),
    .rise   (rise)
  );

  assign tick_at_limit = (tick == LAT_W'(TIMEOUT_US));

  always_ff @(posedge clock) begin
    if (reset) state <= ST_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    clear_run  = 1'b0;
    start_meas = 1'b0;
    capture    = 1'b0;
    timed_out  = 1'b0;
    if (button) begin
      // A button press restarts the run from any state, even mid-capture.
      clear_run  = 1'b1;
      next_state = ST_ARM;
    end else begin
      case (state)
        ST_IDLE: ;
        ST_ARM: begin
          if (starttrigger) begin
            start_meas = 1'b1;
            next_state = ST_MEASURE;
          end
        end
        ST_MEASURE: begin
          // An edge on the same cycle as the limit is still a valid sample.
          if (rise) begin
            capture    = 1'b1;
            next_state = (sample_count == 8'(SAMPLES - 1)) ? ST_DONE : ST_HOLD;
          end else if (tick_at_limit) begin
            timed_out  = 1'b1;
            next_state = ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (!level) next_state = ST_ARM;
        end
        ST_DONE: next_state = ST_IDLE;
        default: next_state = ST_IDLE;
      endcase
    end
  end

  assign busy            = (state == ST_ARM) || (state == ST_MEASURE) || (state == ST_HOLD);
  assign textgen_trigger = (state == ST_DONE) && !button;

  always_ff @(posedge clock) begin
    if (reset) begin
      presc        <= '0;
      tick         <= '0;
      sum          <= '0;
      sample_count <= '0;
      timeout      <= 1'b0;
      lag_last     <= '0;
      lag_min      <= '1;
      lag_max      <= '0;
      lag_avg      <= '0;
    end else begin
      if (clear_run) begin
        sum          <= '0;
        sample_count <= '0;
        timeout      <= 1'b0;
        lag_last     <= '0;
        lag_min      <= '1;
        lag_max      <= '0;
      end

      if (start_meas) begin
        presc <= '0;
        tick  <= '0;
      end else if (state == ST_MEASURE) begin
        if (presc == PW'(US_DIV - 1)) begin
          presc <= '0;
          if (!tick_at_limit) tick <= tick + LAT_W'(1);
        end else begin
          presc <= presc + PW'(1);
        end
      end

      if (capture) begin
        lag_last     <= tick;
        sum          <= sum + SUM_W'(tick);
        sample_count <= sample_count + 8'd1;
        // First sample seeds both extremes regardless of the reset values.
        if (sample_count == 8'd0 || tick < lag_min) lag_min <= tick;
        if (sample_count == 8'd0 || tick > lag_max) lag_max <= tick;
      end

      if (timed_out) timeout <= 1'b1;

      if (textgen_trigger) lag_avg <= LAT_W'(sum >> SW);
    end
  end

endmodule

// File: tb/tb_lag_measure_ctrl.sv
module tb_lag_measure_ctrl;

  localparam int DIV  = 4;
  localparam int S    = 4;
  localparam int TO   = 100;
  localparam int W    = 20;
  localparam int ALL1 = (1 << W) - 1;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         starttrigger = 1'b0;
  logic         sensor = 1'b0;
  logic         button = 1'b0;
  logic         busy;
  logic         textgen_trigger;
  logic         timeout;
  logic [7:0]   sample_count;
  logic [W-1:0] lag_last;
  logic [W-1:0] lag_min;
  logic [W-1:0] lag_max;
  logic [W-1:0] lag_avg;

  lag_measure_ctrl #(
    .US_DIV     (DIV),
    .SAMPLES    (S),
    .TIMEOUT_US (TO),
    .LAT_W      (W)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .starttrigger    (starttrigger),
    .sensor          (sensor),
    .button          (button),
    .busy            (busy),
    .textgen_trigger (textgen_trigger),
    .timeout         (timeout),
    .sample_count    (sample_count),
    .lag_last        (lag_last),
    .lag_min         (lag_min),
    .lag_max         (lag_max),
    .lag_avg         (lag_avg)
  );

  always #5 clock = ~clock;

  int tests    = 0;
  int fails    = 0;
  int trig_cnt = 0;
  int trig_exp = 0;

  // Reference statistics of the current run.
  int m_count, m_sum, m_min, m_max, m_last, m_avg;
  bit m_to;

  always @(negedge clock) if (textgen_trigger === 1'b1) trig_cnt++;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_stats(input string tag);
    chk({tag, "_count"},   32'(sample_count), 32'(m_count));
    chk({tag, "_last"},    32'(lag_last),     32'(m_last));
    chk({tag, "_min"},     32'(lag_min),      32'(m_min));
    chk({tag, "_max"},     32'(lag_max),      32'(m_max));
    chk({tag, "_timeout"}, 32'(timeout),      32'(m_to));
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_busy"}, 32'(busy),            0);
    chk({tag, "_trig"}, 32'(textgen_trigger), 0);
    chk({tag, "_avg"},  32'(lag_avg),         0);
    chk_stats(tag);
  endtask

  task automatic model_clear();
    m_count = 0; m_sum = 0; m_to = 0; m_last = 0; m_max = 0; m_min = ALL1;
  endtask

  task automatic press();
    button = 1'b1;
    step();
    button = 1'b0;
    model_clear();
    chk("press_busy", 32'(busy), 1);
    chk_stats("press");
  endtask

  // One flash: frame start, then sensor first sampled high d cycles later
  // (when has_edge). The measurement is abandoned TO*DIV+1 cycles after the
  // frame start; the edge is captured d+2 cycles after it.
  task automatic flash(input int d, input bit has_edge);
    int limit, end_c, c, lag;
    bit valid;
    limit = TO * DIV + 1;
    valid = has_edge && (d >= 1) && (d + 2 <= limit);
    end_c = valid ? d + 2 : limit;
    starttrigger = 1'b1;
    step();
    starttrigger = 1'b0;
    c = 0;
    while (c < end_c) begin
      if (valid && c == d - 1) sensor = 1'b1;
      if (c == end_c - 1) begin
        chk("pre_count",   32'(sample_count), 32'(m_count));
        chk("pre_timeout", 32'(timeout),      32'(m_to));
      end
      step();
      c++;
    end
    if (valid) begin
      lag = (d + 1) / DIV;
      m_last = lag;
      if (m_count == 0 || lag < m_min) m_min = lag;
      if (m_count == 0 || lag > m_max) m_max = lag;
      m_sum += lag;
      m_count++;
    end else begin
      m_to = 1'b1;
    end
    chk_stats("flash");
    if (m_count == S) begin
      chk("done_trig", 32'(textgen_trigger), 1);
      chk("done_busy", 32'(busy), 0);
      trig_exp++;
      step();
      m_avg = m_sum / S;
      chk("after_done_trig", 32'(textgen_trigger), 0);
      chk("after_done_busy", 32'(busy), 0);
      chk("avg", 32'(lag_avg), 32'(m_avg));
      chk("trig_pulses", 32'(trig_cnt), 32'(trig_exp));
    end else begin
      chk("flash_trig", 32'(textgen_trigger), 0);
      chk("flash_busy", 32'(busy), 1);
      if (valid) begin
        // Still lit: a frame start now must be ignored.
        repeat (3) step();
        starttrigger = 1'b1;
        step();
        starttrigger = 1'b0;
        chk("hold_count", 32'(sample_count), 32'(m_count));
        chk("hold_busy",  32'(busy), 1);
      end
    end
    sensor = 1'b0;
    repeat (4) step();
  endtask

  initial begin
    model_clear();
    m_avg = 0;

    // 1. reset and idle
    repeat (3) step();
    reset = 1'b0;
    chk_reset_state("reset");
    repeat (50) step();
    chk_reset_state("idle");
    chk("idle_trig_pulses", 32'(trig_cnt), 0);

    // 2. single measurement
    press();
    flash(41, 1'b1);

    // 3. full run
    press();
    flash(39, 1'b1);
    flash(47, 1'b1);
    flash(55, 1'b1);
    flash(63, 1'b1);
    chk("run_min", 32'(lag_min), 10);
    chk("run_max", 32'(lag_max), 16);
    chk("run_avg", 32'(lag_avg), 13);
    repeat (20) step();
    chk("run_single_pulse", 32'(trig_cnt), 1);

    // 4. timeout then a normal flash
    press();
    flash(0, 1'b0);
    flash(19, 1'b1);
    chk("after_to_last", 32'(lag_last), 5);

    // 5. edge on the very cycle the limit is reached
    press();
    flash(399, 1'b1);
    chk("limit_last", 32'(lag_last), TO);

    // 6. button restart mid-measure, then reset mid-measure
    press();
    flash(10, 1'b1);
    flash(20, 1'b1);
    starttrigger = 1'b1;
    step();
    starttrigger = 1'b0;
    repeat (20) step();
    press();
    chk("restart_avg_held", 32'(lag_avg), 13);
    flash(30, 1'b1);
    chk("restart_last", 32'(lag_last), 7);
    starttrigger = 1'b1;
    step();
    starttrigger = 1'b0;
    repeat (10) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    model_clear();
    m_avg = 0;
    chk_reset_state("midreset");
    repeat (20) step();
    chk("midreset_trig_pulses", 32'(trig_cnt), 32'(trig_exp));

    // 7. randomized runs
    for (int r = 0; r < 3; r++) begin
      press();
      for (int f = 0; f < 30 && m_count < S; f++) begin
        flash(int'($urandom_range(1, 420)), ($urandom_range(0, 4) != 0));
      end
      repeat (5) step();
      chk("rand_trig_pulses", 32'(trig_cnt), 32'(trig_exp));
      chk("rand_avg", 32'(lag_avg), 32'(m_avg));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/lag_measure_ctrl.md
Name: lag_measure_ctrl

Overview:
- Sequences one input-lag measurement run for the video test generator.
- Arms on a user button and times each test-field flash from the generator's frame-start pulse to the photodiode rising edge, in microsecond ticks.
- Accumulates SAMPLES measurements into last/min/max/average, then pulses the trigger that switches the display from test area to text report.
- Sits between videogen (starttrigger in, textgen_trigger out) and the text/report formatter, which reads the statistics.

Parameters:
- US_DIV, 74, clock cycles per 1 us lag tick; must be >= 2.
- SAMPLES, 16, measurements per run; power of two, 2..128.
- TIMEOUT_US, 500000, tick count at which a pending measurement is abandoned.
- LAT_W, 20, width of lag values in us; must be able to hold TIMEOUT_US.

Ports:
- clock  in  1  pixel clock.
- reset  in  1  synchronous, active-high reset.
- starttrigger  in  1  one-cycle pulse when a flash frame begins.
- sensor  in  1  asynchronous photodiode comparator; high means light.
- button  in  1  one-cycle, already-debounced request to start a new run.
- busy  out  1  high in ARM, MEASURE and HOLD.
- textgen_trigger  out  1  one-cycle pulse when a run completes.
- timeout  out  1  sticky; set when any sample of the current run timed out.
- sample_count  out  8  valid samples taken in the current run.
- lag_last  out  LAT_W  most recent valid sample.
- lag_min  out  LAT_W  minimum valid sample.
- lag_max  out  LAT_W  maximum valid sample.
- lag_avg  out  LAT_W  mean of the valid samples; valid after DONE.

Behaviour:
Reset:
- state = IDLE.
- All outputs 0, except lag_min, which is all-ones.
- Sensor synchroniser flops, prescaler, tick counter and sum are all 0.

Sensor synchroniser:
- Chain sensor -> s1 -> s2 -> sd, one flop per stage.
- edge = s2 & ~sd. Only rising edges count.

States:
- IDLE:
  - button -> ARM. Clear sample_count, sum, timeout and lag_last; lag_max = 0; lag_min = all-ones.
- ARM:
  - Wait for starttrigger.
  - On starttrigger -> MEASURE, with prescaler = 0 and tick = 0.
- MEASURE:
  - Each cycle: prescaler increments; at US_DIV-1 it wraps to 0 and tick increments.
  - On edge: capture the current tick value (before this cycle's update). Set lag_last = tick, min/max update, sum += tick, sample_count += 1.
  - After the capture: if the new sample_count == SAMPLES -> DONE, else -> HOLD.
  - If tick == TIMEOUT_US with no edge: set timeout, discard the sample, go to HOLD.
  - starttrigger in MEASURE is ignored.
- HOLD:
  - Wait for s2 == 0, i.e. the flash has ended, then -> ARM.
  - A starttrigger arriving while in HOLD is not remembered.
- DONE (one cycle):
  - textgen_trigger = 1.
  - lag_avg = sum >> log2(SAMPLES).
  - -> IDLE.

Timing:
- starttrigger sampled at clock edge t0; sensor input first sampled high at edge t0+D.
- Recorded lag = floor((D+1)/US_DIV).
- Fixed sync latency is 2 cycles and is not compensated.

Width and arithmetic:
- tick saturates at TIMEOUT_US.
- sum is LAT_W+log2(SAMPLES) bits wide and never overflows.
- The min/max comparisons on the first sample both update.

Priorities and boundary cases:
- button in any non-IDLE state restarts the run: same clears as from IDLE, -> ARM. button takes priority over edge, timeout and DONE.
- reset mid-run returns everything to reset values. No textgen_trigger is emitted.
- Statistic outputs hold their values in IDLE until the next button.
- edge and the timeout condition in the same cycle: the edge wins and the sample is valid.
- The sensor already high at ARM produces no edge until it falls and rises again.

Decomposition:
- Shared package/defines entries: the state enum (IDLE, ARM, MEASURE, HOLD, DONE), LAT_W, and the flash-frame constants shared with videogen.
- One natural sub-module, lag_sync_edge: the two-flop synchroniser plus rising-edge detector.
- The FSM, prescaler and statistics stay in lag_measure_ctrl.

Test Plan:
Unless stated otherwise, the bench uses US_DIV=4, SAMPLES=4, TIMEOUT_US=100.
1. Reset, then idle for 50 cycles -> busy=0, textgen_trigger never pulses, lag_min=all-ones, all other outputs 0.
2. button; starttrigger; sensor high at D=41 -> lag_last=10, sample_count=1, state HOLD until sensor low, then ARM.
3. Four flashes at D=39,47,55,63 -> lags 10,12,14,16. Then min=10, max=16, avg=13, and exactly one textgen_trigger pulse, one cycle after the 4th capture, with busy=0 afterwards.
4. Flash with no sensor edge -> at tick 100: timeout=1, sample_count unchanged, returns to ARM after HOLD (sensor low). Next flash at D=19 -> lag_last=5.
5. Sensor edge in the same cycle as tick reaching 100 -> sample 100 accepted, timeout stays 0.
6. button during MEASURE after 2 samples -> sample_count=0, timeout=0, ARM. A later reset during MEASURE -> all outputs at reset values, no textgen_trigger.
